// File: rtl/midi_gate_ctrl.sv
// rtl/midi_gate_ctrl.sv - MIDI byte parser producing note gate, pitch and velocity for an envelope generator
module midi_gate_ctrl #(
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       gate_on,
  output logic       gate_off,
  output logic       gate,
  output logic [6:0] note,
  output logic [6:0] velocity
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2,
    SYSEX   = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_status;
  logic [7:0] w_status_nxt;
  logic [6:0] r_d1;
  logic [6:0] w_d1_nxt;
  logic       r_gate_on;
  logic       w_gate_on_nxt;
  logic       r_gate_off;
  logic       w_gate_off_nxt;
  logic       r_gate;
  logic       w_gate_nxt;
  logic [6:0] r_note;
  logic [6:0] w_note_nxt;
  logic [6:0] r_velocity;
  logic [6:0] w_velocity_nxt;

  logic w_is_data;
  logic w_is_chan_status;
  logic w_is_sysex_start;
  logic w_is_sys_common;
  logic w_is_realtime;
  logic w_one_byte_msg;
  logic w_active;
  logic w_note_on_msg;

  // Byte classification on the top bits of the incoming byte.
  assign w_is_data        = ~rx_data[7];
  assign w_is_chan_status = rx_data[7] & (rx_data[7:4] != 4'hF);
  assign w_is_sysex_start = (rx_data == 8'hF0);
  assign w_is_sys_common  = (rx_data[7:3] == 5'b11110) & (rx_data[2:0] != 3'd0);
  assign w_is_realtime    = (rx_data[7:3] == 5'b11111);

  assign w_one_byte_msg = (r_status[7:4] == 4'hC) | (r_status[7:4] == 4'hD);
  assign w_active       = (r_status[3:0] == CHANNEL) &
                          ((r_status[7:4] == 4'h8) | (r_status[7:4] == 4'h9));
  assign w_note_on_msg  = (r_status[7:4] == 4'h9) & (rx_data[6:0] != 7'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_status   <= 8'd0;
      r_d1       <= 7'd0;
      r_gate_on  <= 1'b0;
      r_gate_off <= 1'b0;
      r_gate     <= 1'b0;
      r_note     <= 7'd0;
      r_velocity <= 7'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_status   <= w_status_nxt;
      r_d1       <= w_d1_nxt;
      r_gate_on  <= w_gate_on_nxt;
      r_gate_off <= w_gate_off_nxt;
      r_gate     <= w_gate_nxt;
      r_note     <= w_note_nxt;
      r_velocity <= w_velocity_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_status_nxt   = r_status;
    w_d1_nxt       = r_d1;
    w_gate_on_nxt  = 1'b0;
    w_gate_off_nxt = 1'b0;
    w_gate_nxt     = r_gate;
    w_note_nxt     = r_note;
    w_velocity_nxt = r_velocity;

    if (rx_valid) begin
      // Real-time bytes fall through untouched so they can interleave with any message.
      if (w_is_sysex_start) begin
        w_status_nxt = 8'd0;
        w_state_nxt  = SYSEX;
      end else if (w_is_sys_common) begin
        w_status_nxt = 8'd0;
        w_state_nxt  = IDLE;
      end else if (w_is_chan_status) begin
        w_status_nxt = rx_data;
        w_state_nxt  = WAIT_D1;
      end else if (w_is_data) begin
        case (r_state)
          WAIT_D1: begin
            w_d1_nxt    = rx_data[6:0];
            w_state_nxt = w_one_byte_msg ? WAIT_D1 : WAIT_D2;
          end
          WAIT_D2: begin
            w_state_nxt = WAIT_D1;
            if (w_active) begin
              if (w_note_on_msg) begin
                w_note_nxt     = r_d1;
                w_velocity_nxt = rx_data[6:0];
                w_gate_nxt     = 1'b1;
                w_gate_on_nxt  = 1'b1;
              end else if (r_gate && (r_d1 == r_note)) begin
                w_gate_nxt     = 1'b0;
                w_gate_off_nxt = 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign gate_on  = r_gate_on;
  assign gate_off = r_gate_off;
  assign gate     = r_gate;
  assign note     = r_note;
  assign velocity = r_velocity;

  // Realtime classification is decoded for completeness; it intentionally drives no state.
  logic w_unused;
  assign w_unused = w_is_realtime;

endmodule

// File: tb/tb_midi_gate_ctrl.sv
// tb/tb_midi_gate_ctrl.sv - directed self-checking bench for midi_gate_ctrl
module tb_midi_gate_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       gate_on;
  logic       gate_off;
  logic       gate;
  logic [6:0] note;
  logic [6:0] velocity;

  int n_checks = 0;
  int n_pass   = 0;

  midi_gate_ctrl #(.CHANNEL(4'd0)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .gate_on  (gate_on),
    .gate_off (gate_off),
    .gate     (gate),
    .note     (note),
    .velocity (velocity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drive one byte for one cycle, then sample the registered pulses on the following cycle.
  task automatic send(input logic [7:0] b, input logic exp_on, input logic exp_off);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    chk($sformatf("gate_on after %02h", b), {31'd0, gate_on}, {31'd0, exp_on});
    chk($sformatf("gate_off after %02h", b), {31'd0, gate_off}, {31'd0, exp_off});
  endtask

  task automatic chk_out(input string tag, input logic exp_gate, input logic [6:0] exp_note,
                         input logic [6:0] exp_vel);
    chk({tag, " gate"}, {31'd0, gate}, {31'd0, exp_gate});
    chk({tag, " note"}, {25'd0, note}, {25'd0, exp_note});
    chk({tag, " velocity"}, {25'd0, velocity}, {25'd0, exp_vel});
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset gate_on", {31'd0, gate_on}, 32'd0);
    chk("reset gate_off", {31'd0, gate_off}, 32'd0);
    chk_out("reset", 1'b0, 7'h00, 7'h00);
    rst = 1'b0;

    // Data with no running status after reset is dropped.
    send(8'h3C, 1'b0, 1'b0);
    send(8'h64, 1'b0, 1'b0);
    chk_out("no status", 1'b0, 7'h00, 7'h00);

    // Basic note-on and its one-cycle pulse width.
    send(8'h90, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1'b0);
    send(8'h64, 1'b1, 1'b0);
    chk_out("note on", 1'b1, 7'h3C, 7'h64);
    @(negedge clk);
    chk("gate_on width", {31'd0, gate_on}, 32'd0);

    // Running status retrigger.
    send(8'h3E, 1'b0, 1'b0);
    send(8'h50, 1'b1, 1'b0);
    chk_out("running status", 1'b1, 7'h3E, 7'h50);

    // Note-off for a note that is not current is ignored.
    send(8'h80, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    chk_out("stale off", 1'b1, 7'h3E, 7'h50);
    send(8'h3E, 1'b0, 1'b0);
    send(8'h40, 1'b0, 1'b1);
    chk_out("note off", 1'b0, 7'h3E, 7'h50);
    @(negedge clk);
    chk("gate_off width", {31'd0, gate_off}, 32'd0);

    // Note-off while gate is low has no effect.
    send(8'h3E, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    chk_out("off while idle", 1'b0, 7'h3E, 7'h50);

    // Real-time byte inside a message.
    send(8'h90, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1'b0);
    send(8'hF8, 1'b0, 1'b0);
    send(8'h64, 1'b1, 1'b0);
    chk_out("realtime", 1'b1, 7'h3C, 7'h64);
    send(8'h3C, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b1);
    chk_out("vel0 off", 1'b0, 7'h3C, 7'h64);

    // Other channel, 1-byte program change, and 2-byte 0xEn are all ignored.
    send(8'h91, 1'b0, 1'b0);
    send(8'h40, 1'b0, 1'b0);
    send(8'h7F, 1'b0, 1'b0);
    send(8'hE0, 1'b0, 1'b0);
    send(8'h10, 1'b0, 1'b0);
    send(8'h20, 1'b0, 1'b0);
    send(8'hC0, 1'b0, 1'b0);
    send(8'h05, 1'b0, 1'b0);
    send(8'h06, 1'b0, 1'b0);
    chk_out("ignored msgs", 1'b0, 7'h3C, 7'h64);
    send(8'h90, 1'b0, 1'b0);
    send(8'h41, 1'b0, 1'b0);
    send(8'h20, 1'b1, 1'b0);
    chk_out("after ignored", 1'b1, 7'h41, 7'h20);

    // Reset in the middle of a message discards it.
    send(8'h90, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async reset gate", {31'd0, gate}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h64, 1'b0, 1'b0);
    chk_out("post reset", 1'b0, 7'h00, 7'h00);

    // Sysex payload is discarded and end-of-sysex clears running status.
    send(8'hF0, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1'b0);
    send(8'h64, 1'b0, 1'b0);
    send(8'hF7, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1'b0);
    send(8'h64, 1'b0, 1'b0);
    chk_out("sysex", 1'b0, 7'h00, 7'h00);

    // System common mid-message aborts it.
    send(8'h90, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1'b0);
    send(8'hF3, 1'b0, 1'b0);
    send(8'h64, 1'b0, 1'b0);
    chk_out("sys common", 1'b0, 7'h00, 7'h00);

    // Recovery with a fresh status byte; retrigger pulses while gate already high.
    send(8'h90, 1'b0, 1'b0);
    send(8'h7F, 1'b0, 1'b0);
    send(8'h01, 1'b1, 1'b0);
    send(8'h7F, 1'b0, 1'b0);
    send(8'h7F, 1'b1, 1'b0);
    chk_out("retrigger", 1'b1, 7'h7F, 7'h7F);

    // A status byte interrupting a pending data pair restarts the message.
    send(8'h80, 1'b0, 1'b0);
    send(8'h7F, 1'b0, 1'b0);
    send(8'h80, 1'b0, 1'b0);
    send(8'h7F, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b1);
    chk_out("final off", 1'b0, 7'h7F, 7'h7F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/midi_gate_ctrl.md
MIDI_GATE_CTRL -- requirements
Module: midi_gate_ctrl

Interface
REQ-001 The module SHALL have parameter CHANNEL, default 0, the 4-bit MIDI channel it responds to.
REQ-002 The module SHALL have port clk, input, 1 bit: system clock.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The module SHALL have port rx_data, input, 8 bits: received MIDI byte.
REQ-005 The module SHALL have port rx_valid, input, 1 bit: single-cycle strobe qualifying rx_data; one byte per strobe.
REQ-006 The module SHALL have port gate_on, output, 1 bit: single-cycle note-start pulse, drives adsr_top gate_on.
REQ-007 The module SHALL have port gate_off, output, 1 bit: single-cycle note-release pulse, drives adsr_top gate_off.
REQ-008 The module SHALL have port gate, output, 1 bit: level, high while a note is held.
REQ-009 The module SHALL have port note, output, 7 bits: current note number.
REQ-010 The module SHALL have port velocity, output, 7 bits: current note-on velocity.

Function
REQ-011 The module SHALL sample rx_data only in cycles where rx_valid=1; all other cycles SHALL leave state unchanged.
REQ-012 Byte classes: 0x00-0x7F data; 0x80-0xEF channel status; 0xF0 sysex start; 0xF1-0xF7 system common; 0xF8-0xFF real-time.
REQ-013 The parser SHALL use states IDLE (no running status), WAIT_D1, WAIT_D2 and SYSEX.
REQ-014 A channel status byte SHALL store the status as running status and enter WAIT_D1 from any state.
REQ-015 A running status of 0x8n or 0x9n with n=CHANNEL SHALL be "active"; any other channel status SHALL be "ignored".
REQ-016 Ignored statuses SHALL keep their message length: 0xCn and 0xDn take 1 data byte; all others take 2 data bytes.
REQ-017 In WAIT_D1, a data byte SHALL be latched as d1; the parser SHALL then enter WAIT_D2, or return to WAIT_D1 for 1-byte messages.
REQ-018 In WAIT_D2, a data byte SHALL complete the message and the parser SHALL return to WAIT_D1, giving running status.
REQ-019 Data bytes in IDLE or SYSEX SHALL be discarded.
REQ-020 0xF0 SHALL clear running status and enter SYSEX.
REQ-021 0xF1-0xF7 SHALL clear running status and enter IDLE; 0xF7 is the sysex end.
REQ-022 Real-time bytes SHALL be ignored in every state, leaving state, d1 and running status intact.
REQ-023 A completed active note-on with velocity>0 SHALL set note=d1, velocity=d2 and gate=1, and SHALL pulse gate_on.
REQ-024 gate_on SHALL pulse even when gate is already 1 (retrigger, last-note priority).
REQ-025 A completed active note-off (0x8n, or 0x9n with velocity 0) with gate=1 and d1=note SHALL set gate=0 and pulse gate_off.
REQ-026 Such a note-off SHALL leave note and velocity unchanged.
REQ-027 A note-off whose d1 differs from note, or that arrives while gate=0, SHALL have no effect.
REQ-028 Completed ignored messages SHALL have no effect on any output.
REQ-029 Latency: gate_on and gate_off SHALL be registered and high exactly the one cycle after the rx_valid cycle carrying the completing byte; the gate, note and velocity updates SHALL take effect on that same cycle.
REQ-030 gate_on and gate_off SHALL never be high in the same cycle.

Reset
REQ-031 While rst=1, the parser state SHALL be IDLE.
REQ-032 While rst=1, running status and d1 SHALL be cleared.
REQ-033 While rst=1, gate_on, gate_off, gate, note and velocity SHALL all be 0.
REQ-034 A partially received message SHALL be discarded by reset; data bytes after release are dropped until a new status byte arrives.

Verification
REQ-035 CHANNEL=0; bytes 0x90,0x3C,0x64 -> gate_on high one cycle after the third strobe; note=0x3C, velocity=0x64, gate=1.
REQ-036 Continuing with 0x3E,0x50 (running status) -> gate_on pulse; note=0x3E, velocity=0x50, gate=1.
REQ-037 Then 0x80,0x3C,0x00 -> no gate_off, gate stays 1; then 0x3E,0x40 -> gate_off pulse, gate=0, note stays 0x3E.
REQ-038 Bytes 0x90,0x3C,0xF8,0x64 -> 0xF8 ignored, gate_on pulse, note=0x3C; then 0x3C,0x00 -> gate_off pulse.
REQ-039 Bytes 0x91,0x40,0x7F and 0xC0,0x05,0x90 -> no pulses; then 0x41,0x20 -> gate_on pulse, note=0x41.
REQ-040 Sequence 0x90,0x3C, then rst pulse, then 0x64 -> all outputs 0 and no pulse; 0xF0,0x3C,0x64,0xF7 -> no pulse.
